// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the PC/pipeline control unit: state encoding,
// PC step, NOP encoding, default reset PC and the redirect-target helper.
package rv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REDIRECT = 2'd3
    } pc_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // With misalignment checking the low two bits of a redirect are dropped.
    function automatic logic [31:0] jump_target(input logic [31:0] addr);
`ifdef PC_CTRL_MISALIGN_CHK_EN
        return {addr[31:2], 2'b00};
`else
        return addr;
`endif
    endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch-address handshake between the PC controller (master) and imem (slave).
interface pc_ctrl_if;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        fetch_ready_i;

    modport master (output pc_o, output pc_valid_o, input fetch_ready_i);
    modport slave  (input pc_o, input pc_valid_o, output fetch_ready_i);
endinterface

// File: rtl/pc_redirect_buf.sv
// Holds a redirect target that arrived while the current fetch was back-pressured.
module pc_redirect_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] target_in,
    output logic [31:0] target,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target <= 32'h0;
            valid  <= 1'b0;
        end else if (clear) begin
            valid  <= 1'b0;
        end else if (load) begin
            target <= target_in;
            valid  <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// PC register, fetch request handshake and IF/ID-ID/EX flush/stall control.
// Optional feature macro: PC_CTRL_MISALIGN_CHK_EN (adds misalign_o).
//
// state    | meaning
// ST_IDLE  | post-reset bubble, no fetch request
// ST_RUN   | fetch request at pc_o, advancing on accept
// ST_HOLD  | ex stall, no fetch request, PC frozen
// ST_REDIRECT | old pc_o still pending, buffered target loads on accept
module pc_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] jump_addr_i,
    input  logic        jump_en_i,
    input  logic        hold_flag_i,
    pc_ctrl_if.master   fetch,
    output logic        flush_o,
    output logic        stall_o
`ifdef PC_CTRL_MISALIGN_CHK_EN
    ,
    output logic        misalign_o
`endif
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q;
    logic        accept;
    logic        buf_load, buf_clear, buf_valid;
    logic [31:0] buf_target;

    assign accept           = valid_q & fetch.fetch_ready_i;
    assign fetch.pc_o       = pc_q;
    assign fetch.pc_valid_o = valid_q;
    assign stall_o          = hold_flag_i & ~jump_en_i;

    pc_redirect_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .clear     (buf_clear),
        .target_in (jump_target(jump_addr_i)),
        .target    (buf_target),
        .valid     (buf_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= (state_d == ST_RUN) || (state_d == ST_REDIRECT);
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flush_o   = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                flush_o = jump_en_i;
                if (jump_en_i && (accept || !valid_q)) begin
                    pc_d = jump_target(jump_addr_i);
                end else if (jump_en_i) begin
                    buf_load = 1'b1;
                    state_d  = ST_REDIRECT;
                end else if (stall_o && accept) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = ST_HOLD;
                end else if (accept) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            ST_HOLD: begin
                flush_o = jump_en_i;
                if (jump_en_i) begin
                    pc_d    = jump_target(jump_addr_i);
                    state_d = ST_RUN;
                end else if (!hold_flag_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                // ex only carries a flushed bubble here, so jump_en_i is ignored
                if (accept && buf_valid) begin
                    pc_d      = buf_target;
                    flush_o   = 1'b1;
                    buf_clear = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef PC_CTRL_MISALIGN_CHK_EN
    logic jump_load, jump_mis, mis_q, mis_pend_q;

    assign jump_mis   = jump_addr_i[1:0] != 2'b00;
    assign jump_load  = jump_en_i & (((state_q == ST_RUN) & (accept | ~valid_q)) |
                                     (state_q == ST_HOLD));
    assign misalign_o = mis_q;

    // A buffered redirect carries its misalign flag until it is consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mis_q      <= 1'b0;
            mis_pend_q <= 1'b0;
        end else begin
            mis_q <= (jump_load & jump_mis) | (buf_clear & mis_pend_q);
            if (buf_load)
                mis_pend_q <= jump_mis;
            else if (buf_clear)
                mis_pend_q <= 1'b0;
        end
    end
`endif

endmodule
